// File: rtl/mem_access_unit.sv
// Load/store unit: turns datapath load/store requests into req/ack bus transactions,
// stalling the core until the access retires and flagging misalignment and timeouts.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       off_q;
   logic [2:0]       f3_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             bus_req_q;
   logic             bus_we_q;
   logic [31:0]      bus_addr_q;
   logic [3:0]       bus_be_q;
   logic [31:0]      bus_wdata_q;

   logic        access;
   logic        aligned;
   logic        launch;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] load_c;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Size comes from funct3[1:0]; unlisted encodings fall through to word.
   always_comb begin
      access  = mem_rd | mem_wr;
      aligned = 1'b1;
      be_c    = 4'b1111;
      wdata_c = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr[1:0];
            wdata_c = {4{wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~addr[0];
            be_c    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata[15:0]}};
         end
         default: aligned = (addr[1:0] == 2'b00);
      endcase
      if (!mem_wr) begin
         be_c = 4'b1111;
      end
      launch = access & aligned;
   end

   always_comb begin
      lane_b = bus_rdata[{off_q, 3'b000} +: 8];
      lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (f3_q[1:0])
         2'b00:   load_c = f3_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   load_c = f3_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_c = bus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         off_q       <= 2'b00;
         f3_q        <= 3'b000;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               err_q <= 1'b0;
               if (launch) begin
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= mem_wr;
                  bus_addr_q  <= {addr[31:2], 2'b00};
                  bus_be_q    <= be_c;
                  bus_wdata_q <= wdata_c;
                  off_q       <= addr[1:0];
                  f3_q        <= funct3;
                  cnt_q       <= '0;
                  state_q     <= StReq;
               end
            end
            StReq: begin
               if (bus_ack) begin
                  if (!bus_we_q) begin
                     rdata_q <= load_c;
                  end
                  bus_req_q <= 1'b0;
                  state_q   <= StDone;
               end else if (cnt_q == CntLast) begin
                  rdata_q   <= 32'h0;
                  err_q     <= 1'b1;
                  bus_req_q <= 1'b0;
                  state_q   <= StDone;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StDone: begin
               // The request is still high for the retiring instruction; do not relaunch.
               err_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign misalign  = (state_q == StIdle) & access & ~aligned;
   assign stall     = ((state_q == StIdle) & launch) | (state_q == StReq);
   assign rdata     = (misalign & ~mem_wr) ? 32'h0 : rdata_q;
   assign err       = err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases plus randomized
// accesses checked against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd, mem_wr;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rdata;
   logic        stall, misalign, err;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
      .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
      int n = size_of(f3);
      logic [31:0] v = word >> (8 * off);
      if (n == 4) return word;
      if (n == 1) begin
         v = v & 32'hFF;
         if (!f3[2] && v >= 32'h80) v = v - 32'h100;
      end else begin
         v = v & 32'hFFFF;
         if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
      int n = size_of(f3);
      if (n == 1) return 4'(1 << off);
      if (n == 2) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int n = size_of(f3);
      if (n == 1) return (wd & 32'hFF) * 32'h01010101;
      if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   // Drives one aligned access, acts as the bus slave (ack on REQ cycle ack_lat, -1 = never)
   // and records what was seen; request stays high through the DONE cycle.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int ack_lat,
                             input logic [31:0] rword, output int stalls, output int reqs,
                             output logic [31:0] c_addr, output logic c_we,
                             output logic [3:0] c_be, output logic [31:0] c_wdata,
                             output logic stable, output logic [31:0] d_rdata,
                             output logic d_err, output logic d_req, output logic fin);
      @(posedge clk); #1;
      mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
      stalls = 0; reqs = 0; stable = 1'b1; fin = 1'b0;
      c_addr = 'x; c_we = 'x; c_be = 'x; c_wdata = 'x; d_rdata = 'x; d_err = 'x; d_req = 'x;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         @(negedge clk);
         if (bus_req === 1'b1) begin
            if (reqs == 0) begin
               c_addr = bus_addr; c_we = bus_we; c_be = bus_be; c_wdata = bus_wdata;
            end else if (bus_addr !== c_addr || bus_we !== c_we || bus_be !== c_be ||
                         bus_wdata !== c_wdata) begin
               stable = 1'b0;
            end
            bus_ack   = (reqs == ack_lat);
            bus_rdata = bus_ack ? rword : $urandom;
            reqs++;
         end else begin
            bus_ack = 1'b0;
         end
         if (stall === 1'b1) stalls++;
         else if (stalls > 0) begin
            d_rdata = rdata; d_err = err; d_req = bus_req; fin = 1'b1;
         end
      end
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = 32'h0;
      wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
      total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL rst_bus_we got=%b exp=0", bus_we); end
      total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rst_bus_addr got=%h exp=0", bus_addr); end
      total++; if (bus_be !== 4'h0) begin bad++; $display("FAIL rst_bus_be got=%h exp=0", bus_be); end
      total++; if (bus_wdata !== 32'h0) begin bad++; $display("FAIL rst_bus_wdata got=%h exp=0", bus_wdata); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_rdata = 32'h0;
   endtask

   task automatic test_load_directed();
      logic [2:0]  f3s [4] = '{3'b010, 3'b000, 3'b100, 3'b101};
      logic [31:0] as  [4] = '{32'h100, 32'h103, 32'h103, 32'h102};
      logic [31:0] ws  [4] = '{32'hDEADBEEF, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234};
      logic [31:0] es  [4] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h000080FF};
      int          lats [4] = '{1, 0, 2, 0};
      int stalls, reqs;
      logic [31:0] c_addr, c_wdata, d_rdata;
      logic [3:0]  c_be;
      logic        c_we, stable, d_err, d_req, fin;
      for (int i = 0; i < 4; i++) begin
         run_access(1'b1, 1'b0, f3s[i], as[i], 32'h0, lats[i], ws[i], stalls, reqs, c_addr,
                    c_we, c_be, c_wdata, stable, d_rdata, d_err, d_req, fin);
         total++; if (fin !== 1'b1) begin bad++; $display("FAIL ld_done[%0d] got=%b exp=1", i, fin); end
         total++; if (c_addr !== (as[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL ld_addr[%0d] got=%h exp=%h", i, c_addr, as[i] & 32'hFFFF_FFFC); end
         total++; if (c_be !== 4'hF || c_we !== 1'b0) begin bad++; $display("FAIL ld_be_we[%0d] got=%h/%b exp=f/0", i, c_be, c_we); end
         total++; if (stalls != lats[i] + 2) begin bad++; $display("FAIL ld_stall_cycles[%0d] got=%0d exp=%0d", i, stalls, lats[i] + 2); end
         total++; if (d_rdata !== es[i]) begin bad++; $display("FAIL ld_rdata[%0d] got=%h exp=%h", i, d_rdata, es[i]); end
         total++; if (d_err !== 1'b0 || d_req !== 1'b0) begin bad++; $display("FAIL ld_done_flags[%0d] got=%b%b exp=00", i, d_err, d_req); end
         exp_rdata = es[i];
      end
   endtask

   task automatic test_store_lanes();
      logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
      logic [31:0] as  [3] = '{32'h22, 32'h22, 32'h40};
      logic [31:0] wds [3] = '{32'h000000A5, 32'h00001234, 32'hCAFEF00D};
      logic [3:0]  ebe [3] = '{4'b0100, 4'b1100, 4'b1111};
      logic [31:0] ewd [3] = '{32'hA5A5A5A5, 32'h12341234, 32'hCAFEF00D};
      int stalls, reqs;
      logic [31:0] c_addr, c_wdata, d_rdata;
      logic [3:0]  c_be;
      logic        c_we, stable, d_err, d_req, fin;
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, 1'b1, f3s[i], as[i], wds[i], 1, $urandom, stalls, reqs, c_addr,
                    c_we, c_be, c_wdata, stable, d_rdata, d_err, d_req, fin);
         total++; if (fin !== 1'b1 || c_we !== 1'b1) begin bad++; $display("FAIL st_done_we[%0d] got=%b%b exp=11", i, fin, c_we); end
         total++; if (c_addr !== (as[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, c_addr, as[i] & 32'hFFFF_FFFC); end
         total++; if (c_be !== ebe[i]) begin bad++; $display("FAIL st_be[%0d] got=%b exp=%b", i, c_be, ebe[i]); end
         total++; if (c_wdata !== ewd[i]) begin bad++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, c_wdata, ewd[i]); end
         total++; if (stable !== 1'b1) begin bad++; $display("FAIL st_stable[%0d] got=%b exp=1", i, stable); end
         total++; if (d_rdata !== exp_rdata) begin bad++; $display("FAIL st_rdata_held[%0d] got=%h exp=%h", i, d_rdata, exp_rdata); end
      end
   endtask

   task automatic test_misalign();
      logic        rds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001};
      logic [31:0] as  [5] = '{32'h101, 32'h103, 32'h201, 32'h22, 32'h45};
      logic [31:0] want;
      int          req_seen;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         mem_rd = rds[i]; mem_wr = ~rds[i]; funct3 = f3s[i]; addr = as[i]; wdata = $urandom;
         want = rds[i] ? 32'h0 : exp_rdata;
         req_seen = 0;
         @(negedge clk);
         total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag[%0d] got=%b exp=1", i, misalign); end
         total++; if (stall !== 1'b0) begin bad++; $display("FAIL mis_stall[%0d] got=%b exp=0", i, stall); end
         total++; if (rdata !== want) begin bad++; $display("FAIL mis_rdata[%0d] got=%h exp=%h", i, rdata, want); end
         for (int k = 0; k < 3; k++) begin
            if (bus_req !== 1'b0) req_seen++;
            @(negedge clk);
         end
         total++; if (req_seen != 0) begin bad++; $display("FAIL mis_no_bus[%0d] got=%0d exp=0", i, req_seen); end
         @(posedge clk); #1;
         mem_rd = 1'b0; mem_wr = 1'b0;
         @(negedge clk);
         total++; if (misalign !== 1'b0 || rdata !== exp_rdata) begin bad++; $display("FAIL mis_after[%0d] got=%b/%h exp=0/%h", i, misalign, rdata, exp_rdata); end
      end
   endtask

   task automatic test_timeout();
      int stalls, reqs;
      logic [31:0] c_addr, c_wdata, d_rdata;
      logic [3:0]  c_be;
      logic        c_we, stable, d_err, d_req, fin;
      run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, -1, 32'h0, stalls, reqs, c_addr, c_we,
                 c_be, c_wdata, stable, d_rdata, d_err, d_req, fin);
      exp_rdata = 32'h0;
      total++; if (fin !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", fin); end
      total++; if (reqs != 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", reqs); end
      total++; if (stalls != 17) begin bad++; $display("FAIL to_stall_cycles got=%0d exp=17", stalls); end
      total++; if (d_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", d_err); end
      total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", d_rdata); end
      @(negedge clk);
      total++; if (err !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL to_idle got=%b%b%b exp=000", err, stall, bus_req); end
   endtask

   task automatic test_reset_mid_req();
      int stalls, reqs, req_seen;
      logic [31:0] c_addr, c_wdata, d_rdata;
      logic [3:0]  c_be;
      logic        c_we, stable, d_err, d_req, fin;
      run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h13579BDF, stalls, reqs, c_addr,
                 c_we, c_be, c_wdata, stable, d_rdata, d_err, d_req, fin);
      total++; if (d_rdata !== 32'h13579BDF) begin bad++; $display("FAIL rr_preload got=%h exp=13579bdf", d_rdata); end
      @(posedge clk); #1;
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h304; bus_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rr_in_req got=%b exp=1", bus_req); end
      @(posedge clk); #1;
      rst = 1'b1; mem_rd = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b%b exp=00", bus_req, stall); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rr_rdata got=%h exp=0", rdata); end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      req_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus_req !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) req_seen++;
      end
      total++; if (req_seen != 0) begin bad++; $display("FAIL rr_late_ack got=%0d exp=0", req_seen); end
      exp_rdata = 32'h0;
   endtask

   task automatic test_back_to_back();
      int stalls, reqs, req_seen;
      logic [31:0] c_addr, c_wdata, d_rdata;
      logic [3:0]  c_be;
      logic        c_we, stable, d_err, d_req, fin;
      for (int i = 0; i < 2; i++) begin
         run_access(1'b1, 1'b0, 3'b010, 32'h400 + 32'(4 * i), 32'h0, 0, 32'h0BAD0000 + 32'(i),
                    stalls, reqs, c_addr, c_we, c_be, c_wdata, stable, d_rdata, d_err, d_req,
                    fin);
         total++; if (reqs != 1) begin bad++; $display("FAIL b2b_one_txn[%0d] got=%0d exp=1", i, reqs); end
         total++; if (stalls != 2) begin bad++; $display("FAIL b2b_min_latency[%0d] got=%0d exp=2", i, stalls); end
         total++; if (d_rdata !== 32'h0BAD0000 + 32'(i)) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, d_rdata, 32'h0BAD0000 + 32'(i)); end
         exp_rdata = 32'h0BAD0000 + 32'(i);
      end
      req_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus_req !== 1'b0) req_seen++;
      end
      total++; if (req_seen != 0) begin bad++; $display("FAIL b2b_no_relaunch got=%0d exp=0", req_seen); end
   endtask

   task automatic test_random();
      logic [2:0]  ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  f3;
      logic [31:0] a, wd, rword;
      logic        rd, wr;
      int          kind, lat, n, stalls, reqs;
      logic [31:0] c_addr, c_wdata, d_rdata, want;
      logic [3:0]  c_be;
      logic        c_we, stable, d_err, d_req, fin;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         rd = (kind != 1); wr = (kind != 0);
         f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3s[$urandom_range(0, 4)];
         n = size_of(f3);
         a = $urandom & ~(32'(n) - 32'h1);
         wd = $urandom; rword = $urandom; lat = $urandom_range(0, 3);
         run_access(rd, wr, f3, a, wd, lat, rword, stalls, reqs, c_addr, c_we, c_be, c_wdata,
                    stable, d_rdata, d_err, d_req, fin);
         if (!wr) exp_rdata = ref_load(f3, a[1:0], rword);
         total++; if (fin !== 1'b1 || reqs != lat + 1 || stalls != lat + 2) begin bad++; $display("FAIL rnd_timing[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, fin, reqs, stalls, lat + 1, lat + 2); end
         total++; if (c_addr !== {a[31:2], 2'b00} || c_we !== wr || stable !== 1'b1) begin bad++; $display("FAIL rnd_bus[%0d] got=%h/%b/%b exp=%h/%b/1", i, c_addr, c_we, stable, {a[31:2], 2'b00}, wr); end
         want = wr ? {28'h0, ref_be(f3, a[1:0])} : 32'hF;
         total++; if ({28'h0, c_be} !== want) begin bad++; $display("FAIL rnd_be[%0d] got=%h exp=%h", i, c_be, want); end
         if (wr) begin
            total++; if (c_wdata !== ref_wdata(f3, wd)) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, c_wdata, ref_wdata(f3, wd)); end
         end
         total++; if (d_rdata !== exp_rdata || d_err !== 1'b0) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h/%b exp=%h/0", i, d_rdata, d_err, exp_rdata); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_load_directed();
      test_store_lanes();
      test_misalign();
      test_timeout();
      test_reset_mid_req();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
